// File: rtl/memory_game_pkg.sv
// Shared types and width helpers for the card-matching game core.
package memory_game_pkg;

    localparam int unsigned CARD_W  = 2;
    localparam int unsigned STATE_W = 3;

    typedef enum logic [CARD_W-1:0] {
        HIDDEN  = 2'd0,
        FLIPPED = 2'd1,
        MATCHED = 2'd2
    } card_state_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_PICK1  = 3'd1,
        ST_PICK2  = 3'd2,
        ST_REVEAL = 3'd3,
        ST_OVER   = 3'd4
    } game_state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int unsigned width_of(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/memory_game_ctrl_turn_timer.sv
// Per-turn tick countdown: reloads to TURN_TICKS, decrements on tick,
// flags when the next decrement will expire the turn.
module turn_timer
    import memory_game_pkg::*;
#(
    parameter  int unsigned TURN_TICKS = 10,
    localparam int unsigned TW         = width_of(TURN_TICKS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          dec_i,
    output logic [TW-1:0] count_o,
    output logic          last_o
);

    logic [TW-1:0] count_q, count_d;

    // Reload has priority over decrement so an expiring turn restarts cleanly.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = TW'(TURN_TICKS);
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= TW'(TURN_TICKS);
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == TW'(1));

endmodule

// File: rtl/memory_game_ctrl.sv
// Game-logic core for the concentration card game: turn FSM, deck symbol
// RAM, per-card state, per-player scores and end-of-game winner compare.
module memory_game_ctrl
    import memory_game_pkg::*;
#(
    parameter int unsigned N_CARDS     = 16,
    parameter int unsigned N_PLAYERS   = 2,
    parameter int unsigned SYM_W       = 3,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned SHOW_CYCLES = 25_000_000,
    parameter int unsigned TURN_TICKS  = 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             tick_i,
    input  logic                             move_i,
    input  logic                             select_i,
    input  logic                             start_i,
    input  logic                             deck_we_i,
    input  logic [$clog2(N_CARDS)-1:0]       deck_addr_i,
    input  logic [SYM_W-1:0]                 deck_sym_i,
    output logic [$clog2(N_CARDS)-1:0]       cursor_o,
    output logic [2*N_CARDS-1:0]             card_state_o,
    output logic [$clog2(N_PLAYERS)-1:0]     cur_player_o,
    output logic [N_PLAYERS*SCORE_W-1:0]     score_o,
    output logic [$clog2(TURN_TICKS+1)-1:0]  time_left_o,
    output logic [2:0]                       game_state_o,
    output logic [$clog2(N_PLAYERS)-1:0]     winner_o,
    output logic                             tie_o
);

    localparam int unsigned CW  = $clog2(N_CARDS);
    localparam int unsigned PW  = $clog2(N_PLAYERS);
    localparam int unsigned TW  = width_of(TURN_TICKS + 1);
    localparam int unsigned SHW = width_of(SHOW_CYCLES);
    localparam int unsigned PLW = width_of(N_CARDS / 2 + 1);

    game_state_e        state_q, state_d;
    card_state_e        card_q [N_CARDS];
    card_state_e        card_d [N_CARDS];
    logic [SYM_W-1:0]   sym_q  [N_CARDS];
    logic [SYM_W-1:0]   sym_d  [N_CARDS];
    logic [SCORE_W-1:0] score_q [N_PLAYERS];
    logic [SCORE_W-1:0] score_d [N_PLAYERS];
    logic [CW-1:0]      cursor_q, cursor_d;
    logic [CW-1:0]      idx1_q, idx1_d;
    logic [CW-1:0]      idx2_q, idx2_d;
    logic [PW-1:0]      player_q, player_d;
    logic [PLW-1:0]     pairs_q, pairs_d;
    logic [SHW-1:0]     show_q, show_d;
    logic [PW-1:0]      winner_q, win_c;
    logic               tie_q, tie_c;
    logic [SCORE_W-1:0] best_c;
    int unsigned        n_top_c;

    logic               timer_load, timer_dec, timer_last;
    logic [TW-1:0]      time_left;
    logic               sel_hit;
    logic               in_play;
    logic [PW-1:0]      next_player;

    turn_timer #(
        .TURN_TICKS (TURN_TICKS)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (timer_load),
        .dec_i   (timer_dec),
        .count_o (time_left),
        .last_o  (timer_last)
    );

    assign sel_hit     = select_i && (card_q[cursor_q] == HIDDEN);
    assign in_play     = (state_q == ST_PICK1) || (state_q == ST_PICK2) || (state_q == ST_REVEAL);
    assign next_player = (player_q == PW'(N_PLAYERS - 1)) ? '0 : player_q + 1'b1;

    // Next-state logic for the turn FSM and all game bookkeeping.
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        idx1_d     = idx1_q;
        idx2_d     = idx2_q;
        player_d   = player_q;
        pairs_d    = pairs_q;
        show_d     = show_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        for (int unsigned i = 0; i < N_CARDS; i++) begin
            card_d[i] = card_q[i];
            sym_d[i]  = sym_q[i];
        end
        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
            score_d[p] = score_q[p];
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (deck_we_i) begin
                    sym_d[deck_addr_i] = deck_sym_i;
                end
                if (start_i) begin
                    state_d    = ST_PICK1;
                    cursor_d   = '0;
                    player_d   = '0;
                    pairs_d    = PLW'(N_CARDS / 2);
                    timer_load = 1'b1;
                    for (int unsigned i = 0; i < N_CARDS; i++) begin
                        card_d[i] = HIDDEN;
                    end
                    for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                        score_d[p] = '0;
                    end
                end
            end
            ST_PICK1: begin
                if (sel_hit) begin
                    card_d[cursor_q] = FLIPPED;
                    idx1_d           = cursor_q;
                    state_d          = ST_PICK2;
                end
                if (tick_i) begin
                    timer_dec = 1'b1;
                    if (timer_last) begin
                        // A first pick made in the expiring cycle is turned back over.
                        if (sel_hit) begin
                            card_d[cursor_q] = HIDDEN;
                        end
                        player_d   = next_player;
                        timer_load = 1'b1;
                        state_d    = ST_PICK1;
                    end
                end
            end
            ST_PICK2: begin
                if (sel_hit) begin
                    // Completing the pair swallows any same-cycle tick.
                    card_d[cursor_q] = FLIPPED;
                    idx2_d           = cursor_q;
                    show_d           = '0;
                    state_d          = ST_REVEAL;
                end else if (tick_i) begin
                    timer_dec = 1'b1;
                    if (timer_last) begin
                        card_d[idx1_q] = HIDDEN;
                        player_d       = next_player;
                        timer_load     = 1'b1;
                        state_d        = ST_PICK1;
                    end
                end
            end
            ST_REVEAL: begin
                if (show_q == SHW'(SHOW_CYCLES - 1)) begin
                    timer_load = 1'b1;
                    if (sym_q[idx1_q] == sym_q[idx2_q]) begin
                        card_d[idx1_q] = MATCHED;
                        card_d[idx2_q] = MATCHED;
                        if (score_q[player_q] != '1) begin
                            score_d[player_q] = score_q[player_q] + 1'b1;
                        end
                        pairs_d = pairs_q - 1'b1;
                        state_d = (pairs_q == PLW'(1)) ? ST_OVER : ST_PICK1;
                    end else begin
                        card_d[idx1_q] = HIDDEN;
                        card_d[idx2_q] = HIDDEN;
                        player_d       = next_player;
                        state_d        = ST_PICK1;
                    end
                end else begin
                    show_d = show_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (move_i && in_play) begin
            cursor_d = (cursor_q == CW'(N_CARDS - 1)) ? '0 : cursor_q + 1'b1;
        end
    end

    // Highest post-update score, lowest index on ties, plus tie detection.
    always_comb begin
        win_c   = '0;
        best_c  = score_d[0];
        n_top_c = 0;
        tie_c   = 1'b0;
        for (int unsigned p = 1; p < N_PLAYERS; p++) begin
            if (score_d[p] > best_c) begin
                best_c = score_d[p];
                win_c  = PW'(p);
            end
        end
        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
            if (score_d[p] == best_c) begin
                n_top_c = n_top_c + 1;
            end
        end
        tie_c = (n_top_c > 1);
    end

    // State, deck, card and score registers; winner captured on entry to OVER.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cursor_q <= '0;
            idx1_q   <= '0;
            idx2_q   <= '0;
            player_q <= '0;
            pairs_q  <= PLW'(N_CARDS / 2);
            show_q   <= '0;
            winner_q <= '0;
            tie_q    <= 1'b0;
            for (int unsigned i = 0; i < N_CARDS; i++) begin
                card_q[i] <= HIDDEN;
                sym_q[i]  <= '0;
            end
            for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                score_q[p] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cursor_q <= cursor_d;
            idx1_q   <= idx1_d;
            idx2_q   <= idx2_d;
            player_q <= player_d;
            pairs_q  <= pairs_d;
            show_q   <= show_d;
            for (int unsigned i = 0; i < N_CARDS; i++) begin
                card_q[i] <= card_d[i];
                sym_q[i]  <= sym_d[i];
            end
            for (int unsigned p = 0; p < N_PLAYERS; p++) begin
                score_q[p] <= score_d[p];
            end
            if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
                winner_q <= win_c;
                tie_q    <= tie_c;
            end else if (((state_q == ST_IDLE) || (state_q == ST_OVER)) && start_i) begin
                winner_q <= '0;
                tie_q    <= 1'b0;
            end
        end
    end

    // Flatten per-card and per-player registers onto the output buses.
    always_comb begin
        card_state_o = '0;
        score_o      = '0;
        for (int unsigned i = 0; i < N_CARDS; i++) begin
            card_state_o[2*i +: 2] = card_q[i];
        end
        for (int unsigned p = 0; p < N_PLAYERS; p++) begin
            score_o[p*SCORE_W +: SCORE_W] = score_q[p];
        end
    end

    assign cursor_o     = cursor_q;
    assign cur_player_o = player_q;
    assign time_left_o  = time_left;
    assign game_state_o = state_q;
    assign winner_o     = winner_q;
    assign tie_o        = tie_q;

endmodule
